dma_psdpram_sc: RTL and testbench



---
 rtl/dma_psdpram_sc.sv | 148 ++++++++++++++
 tb/tb_dma_psdpram_sc.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_psdpram_sc.sv
// dma_psdpram_sc -- segmented pseudo-dual-port RAM, single clock.
//
// Each of SEG_COUNT segments is an independent SEG_DATA_WIDTH-wide RAM.
// Every segment has one byte-enabled write port and one read port. The read
// port feeds a PIPELINE-deep elastic pipeline with backpressure.
//
// Ports (all vectors are packed per segment, segment 0 in the low slice):
//   clk, rst_n       clock, asynchronous active-low reset
//   wr_cmd_*         write command: be / addr / data, valid-ready handshake
//   rd_cmd_*         read command: addr, valid-ready handshake
//   rd_resp_*        read response: data, valid-ready handshake
//   rd_wr_collision  one-cycle pulse after a same-address read+write accept
//
// Build option: define DMA_PSDPRAM_SC_FWD_EN to return the byte-merged new
// word on a same-address read/write collision. Without it, the read returns
// the old word.
module dma_psdpram_sc #(
  parameter int SIZE           = 4096,
  parameter int SEG_COUNT      = 2,
  parameter int SEG_DATA_WIDTH = 128,
  parameter int SEG_ADDR_WIDTH = 8,
  parameter int SEG_BE_WIDTH   = SEG_DATA_WIDTH/8,
  parameter int PIPELINE       = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [SEG_COUNT*SEG_BE_WIDTH-1:0]   wr_cmd_be,
  input  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] wr_cmd_addr,
  input  logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] wr_cmd_data,
  input  logic [SEG_COUNT-1:0]                wr_cmd_valid,
  output logic [SEG_COUNT-1:0]                wr_cmd_ready,
  input  logic [SEG_COUNT*SEG_ADDR_WIDTH-1:0] rd_cmd_addr,
  input  logic [SEG_COUNT-1:0]                rd_cmd_valid,
  output logic [SEG_COUNT-1:0]                rd_cmd_ready,
  output logic [SEG_COUNT*SEG_DATA_WIDTH-1:0] rd_resp_data,
  output logic [SEG_COUNT-1:0]                rd_resp_valid,
  input  logic [SEG_COUNT-1:0]                rd_resp_ready,
  output logic [SEG_COUNT-1:0]                rd_wr_collision
);

  localparam int INT_ADDR_WIDTH = $clog2(SIZE/(SEG_COUNT*SEG_BE_WIDTH));
  localparam int DEPTH          = 2**INT_ADDR_WIDTH;
  localparam int BYTE_W         = SEG_DATA_WIDTH/SEG_BE_WIDTH;

  if (SEG_ADDR_WIDTH < INT_ADDR_WIDTH) begin : g_bad_addr
    $error("dma_psdpram_sc: SEG_ADDR_WIDTH too small for SIZE/SEG_COUNT");
  end
  if (PIPELINE < 1 || PIPELINE > 8) begin : g_bad_pipe
    $error("dma_psdpram_sc: PIPELINE must be in 1..8");
  end

  // Replace the bytes selected by be with new data, keep the rest.
  function automatic logic [SEG_DATA_WIDTH-1:0] byte_merge(
    input logic [SEG_DATA_WIDTH-1:0] old_word,
    input logic [SEG_DATA_WIDTH-1:0] new_word,
    input logic [SEG_BE_WIDTH-1:0]   be
  );
    logic [SEG_DATA_WIDTH-1:0] r;
    r = old_word;
    for (int b = 0; b < SEG_BE_WIDTH; b++)
      if (be[b]) r[b*BYTE_W +: BYTE_W] = new_word[b*BYTE_W +: BYTE_W];
    return r;
  endfunction

  // Upper address bits beyond INT_ADDR_WIDTH are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{wr_cmd_addr, rd_cmd_addr};

  // Write-ready is a plain register so it stays low until the first edge
  // after reset release; this also blocks writes while rst_n is low.
  logic wr_rdy_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_rdy_q <= 1'b0;
    else        wr_rdy_q <= 1'b1;
  end
  assign wr_cmd_ready = {SEG_COUNT{wr_rdy_q}};

  for (genvar n = 0; n < SEG_COUNT; n++) begin : g_seg
    logic [SEG_DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    logic [INT_ADDR_WIDTH-1:0] waddr, raddr;
    logic [SEG_BE_WIDTH-1:0]   be;
    logic [SEG_DATA_WIDTH-1:0] wdata, rword;
    logic                      wr_fire, rd_fire, rd_rdy, same_addr;
    logic [PIPELINE-1:0]       vld_p, en_p;
    logic [SEG_DATA_WIDTH-1:0] data_p [PIPELINE];
    logic                      coll_q;

    assign waddr     = wr_cmd_addr[n*SEG_ADDR_WIDTH +: INT_ADDR_WIDTH];
    assign raddr     = rd_cmd_addr[n*SEG_ADDR_WIDTH +: INT_ADDR_WIDTH];
    assign be        = wr_cmd_be[n*SEG_BE_WIDTH +: SEG_BE_WIDTH];
    assign wdata     = wr_cmd_data[n*SEG_DATA_WIDTH +: SEG_DATA_WIDTH];
    assign wr_fire   = wr_cmd_valid[n] & wr_rdy_q;
    assign rd_fire   = rd_cmd_valid[n] & rd_rdy;
    assign same_addr = (waddr == raddr);

    // Stage enables ripple back from the response port: a stage may load
    // when every stage downstream of it either is empty or drains this cycle.
    always_comb begin
      logic chain;
      en_p  = '0;
      chain = rd_resp_ready[n] | ~vld_p[PIPELINE-1];
      en_p[PIPELINE-1] = chain;
      for (int k = PIPELINE-2; k >= 0; k--) begin
        chain   = ~vld_p[k+1] | chain;
        en_p[k] = chain;
      end
    end

    assign rd_rdy          = en_p[0] & rst_n;
    assign rd_cmd_ready[n] = rd_rdy;

`ifdef DMA_PSDPRAM_SC_FWD_EN
    assign rword = (wr_fire && same_addr) ? byte_merge(mem[raddr], wdata, be)
                                          : mem[raddr];
`else
    assign rword = mem[raddr];
`endif

    always_ff @(posedge clk) begin
      if (wr_fire) mem[waddr] <= byte_merge(mem[waddr], wdata, be);
    end

    // p0: RAM read captured at accept; p1..: elastic stages toward response
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_p  <= '0;
        coll_q <= 1'b0;
      end else begin
        if (en_p[0]) vld_p[0] <= rd_fire;
        for (int k = 1; k < PIPELINE; k++)
          if (en_p[k]) vld_p[k] <= vld_p[k-1];
        coll_q <= wr_fire & rd_fire & same_addr;
      end
    end

    always_ff @(posedge clk) begin
      if (en_p[0]) data_p[0] <= rword;
      for (int k = 1; k < PIPELINE; k++)
        if (en_p[k]) data_p[k] <= data_p[k-1];
    end

    assign rd_resp_valid[n]                                   = vld_p[PIPELINE-1];
    assign rd_resp_data[n*SEG_DATA_WIDTH +: SEG_DATA_WIDTH]   = data_p[PIPELINE-1];
    assign rd_wr_collision[n]                                 = coll_q;
  end

endmodule

// File: tb/tb_dma_psdpram_sc.sv
// Testbench for dma_psdpram_sc (default parameters): directed stimulus,
// scoreboard queues per segment, separate response monitor.
module tb_dma_psdpram_sc;
  localparam int NS   = 2;
  localparam int DW   = 128;
  localparam int AW   = 8;
  localparam int BW   = 16;
  localparam int PIPE = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NS*BW-1:0]  wr_cmd_be;
  logic [NS*AW-1:0]  wr_cmd_addr;
  logic [NS*DW-1:0]  wr_cmd_data;
  logic [NS-1:0]     wr_cmd_valid;
  logic [NS-1:0]     wr_cmd_ready;
  logic [NS*AW-1:0]  rd_cmd_addr;
  logic [NS-1:0]     rd_cmd_valid;
  logic [NS-1:0]     rd_cmd_ready;
  logic [NS*DW-1:0]  rd_resp_data;
  logic [NS-1:0]     rd_resp_valid;
  logic [NS-1:0]     rd_resp_ready;
  logic [NS-1:0]     rd_wr_collision;

  dma_psdpram_sc dut (
    .clk(clk), .rst_n(rst_n),
    .wr_cmd_be(wr_cmd_be), .wr_cmd_addr(wr_cmd_addr), .wr_cmd_data(wr_cmd_data),
    .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready),
    .rd_cmd_addr(rd_cmd_addr), .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready),
    .rd_resp_data(rd_resp_data), .rd_resp_valid(rd_resp_valid), .rd_resp_ready(rd_resp_ready),
    .rd_wr_collision(rd_wr_collision)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] d;
    int            c;
    bit            lat;
  } exp_t;
  exp_t sbq[NS][$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rep(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic wr(input int s, input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [BW-1:0] be);
    int t;
    t = 0;
    wr_cmd_addr[s*AW +: AW] = a;
    wr_cmd_data[s*DW +: DW] = d;
    wr_cmd_be[s*BW +: BW]   = be;
    wr_cmd_valid[s]         = 1'b1;
    @(negedge clk);
    while (!wr_cmd_ready[s] && t < 200) begin
      t++;
      @(negedge clk);
    end
    chk("wr_ready_wait", DW'(wr_cmd_ready[s]), DW'(1));
    @(posedge clk); #1;
    wr_cmd_valid[s] = 1'b0;
  endtask

  task automatic rd(input int s, input logic [AW-1:0] a, input logic [DW-1:0] exp,
                    input bit lat);
    int t;
    t = 0;
    rd_cmd_addr[s*AW +: AW] = a;
    rd_cmd_valid[s]         = 1'b1;
    @(negedge clk);
    while (!rd_cmd_ready[s] && t < 200) begin
      t++;
      @(negedge clk);
    end
    chk("rd_ready_wait", DW'(rd_cmd_ready[s]), DW'(1));
    if (rd_cmd_ready[s]) sbq[s].push_back('{exp, cyc, lat});
    @(posedge clk); #1;
    rd_cmd_valid[s] = 1'b0;
  endtask

  // Response monitor: pops the scoreboard on each accepted response and
  // checks that stalled responses hold their data.
  initial begin : mon
    logic [DW-1:0] hold_d [NS];
    bit            hold   [NS];
    logic [DW-1:0] d;
    exp_t          e;
    for (int s = 0; s < NS; s++) begin hold[s] = 1'b0; hold_d[s] = '0; end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int s = 0; s < NS; s++) hold[s] = 1'b0;
      end else begin
        for (int s = 0; s < NS; s++) begin
          d = rd_resp_data[s*DW +: DW];
          if (hold[s]) begin
            chk("stall_valid", DW'(rd_resp_valid[s]), DW'(1));
            chk("stall_data", d, hold_d[s]);
          end
          if (rd_resp_valid[s] && rd_resp_ready[s]) begin
            if (sbq[s].size() == 0) begin
              chk("unexpected_resp", DW'(rd_resp_valid[s]), DW'(0));
            end else begin
              e = sbq[s].pop_front();
              chk($sformatf("resp_data_seg%0d", s), d, e.d);
              if (e.lat) chk("resp_latency", DW'(cyc), DW'(e.c + PIPE));
            end
          end
          hold[s]   = rd_resp_valid[s] & ~rd_resp_ready[s];
          hold_d[s] = d;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [DW-1:0] coll_exp;
    rst_n         = 1'b0;
    wr_cmd_be     = '0;
    wr_cmd_addr   = '0;
    wr_cmd_data   = '0;
    wr_cmd_valid  = '0;
    rd_cmd_addr   = '0;
    rd_cmd_valid  = '0;
    rd_resp_ready = '1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_wr_ready", DW'(wr_cmd_ready), DW'(0));
    chk("rst_rd_ready", DW'(rd_cmd_ready), DW'(0));
    chk("rst_resp_valid", DW'(rd_resp_valid), DW'(0));
    chk("rst_collision", DW'(rd_wr_collision), DW'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("wr_ready_before_edge", DW'(wr_cmd_ready), DW'(0));
    @(negedge clk);
    chk("wr_ready_after_edge", DW'(wr_cmd_ready), DW'(2'b11));
    @(posedge clk); #1;

    // Unwritten memory reads as zero
    rd(0, 8'd5, '0, 1'b1);

    // Full-word write then read
    wr(0, 8'd3, rep(8'hA5), '1);
    @(posedge clk); #1;
    rd(0, 8'd3, rep(8'hA5), 1'b1);
    // Upper address bit ignored
    rd(0, 8'h83, rep(8'hA5), 1'b1);
    // be=0 leaves the word alone
    wr(0, 8'd3, rep(8'hFF), '0);
    rd(0, 8'd3, rep(8'hA5), 1'b1);

    // Same-cycle read/write collision
    wr(0, 8'd9, rep(8'h11), '1);
`ifdef DMA_PSDPRAM_SC_FWD_EN
    coll_exp = {{15{8'h11}}, 8'h22};
`else
    coll_exp = rep(8'h11);
`endif
    fork
      wr(0, 8'd9, rep(8'h22), 16'h0001);
      rd(0, 8'd9, coll_exp, 1'b1);
    join
    @(negedge clk);
    chk("collision_pulse", DW'(rd_wr_collision), DW'(2'b01));
    @(negedge clk);
    chk("collision_clear", DW'(rd_wr_collision), DW'(0));
    @(posedge clk); #1;
    rd(0, 8'd9, {{15{8'h11}}, 8'h22}, 1'b1);

    // No collision for different addresses or across segments
    fork
      wr(0, 8'd12, rep(8'h5A), '1);
      rd(0, 8'd13, '0, 1'b1);
      rd(1, 8'd12, '0, 1'b1);
    join
    @(negedge clk);
    chk("no_collision", DW'(rd_wr_collision), DW'(0));
    @(posedge clk); #1;

    // Segment independence at identical addresses
    fork
      wr(0, 8'd7, rep(8'h3C), '1);
      wr(1, 8'd7, rep(8'hC3), '1);
    join
    fork
      rd(0, 8'd7, rep(8'h3C), 1'b1);
      rd(1, 8'd7, rep(8'hC3), 1'b1);
    join
    rd(1, 8'd3, '0, 1'b1);

    // Backpressure: 8 back-to-back reads with response port stalled
    for (int i = 0; i < 8; i++) wr(0, AW'(16 + i), rep(8'(8'h40 + i)), '1);
    rd_resp_ready = '0;
    fork
      begin
        for (int i = 0; i < 8; i++) rd(0, AW'(16 + i), rep(8'(8'h40 + i)), 1'b0);
      end
      begin
        repeat (6) @(negedge clk);
        chk("stall_cmd_ready", DW'(rd_cmd_ready[0]), DW'(0));
        chk("stall_accepted", DW'(sbq[0].size()), DW'(PIPE));
        @(posedge clk); #1;
        rd_resp_ready = '1;
      end
    join
    repeat (PIPE + 2) @(posedge clk);
    #1;

    // Reset with two reads in flight
    rd_resp_ready = '0;
    rd(0, 8'd3, rep(8'hA5), 1'b0);
    rd(0, 8'd9, rep(8'h11), 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("inflight_rst_valid", DW'(rd_resp_valid), DW'(0));
    chk("inflight_rst_cmd_ready", DW'(rd_cmd_ready), DW'(0));
    sbq[0].delete();
    wr_cmd_addr[0 +: AW]  = 8'd3;
    wr_cmd_data[0 +: DW]  = rep(8'hFF);
    wr_cmd_be[0 +: BW]    = '1;
    wr_cmd_valid[0]       = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wr_blocked", DW'(wr_cmd_ready), DW'(0));
    wr_cmd_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst_n         = 1'b1;
    rd_resp_ready = '1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale_resp", DW'(rd_resp_valid), DW'(0));
    end
    @(posedge clk); #1;
    // Memory survives reset and the write during reset did not land
    rd(0, 8'd3, rep(8'hA5), 1'b1);

    // Drain
    for (int i = 0; i < 100 && (sbq[0].size() != 0 || sbq[1].size() != 0); i++)
      @(posedge clk);
    chk("drain_seg0", DW'(sbq[0].size()), DW'(0));
    chk("drain_seg1", DW'(sbq[1].size()), DW'(0));
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
